axil_reg_bank: RTL and testbench

//  AXI4-Lite slave register bank; sits directly downstream of the sgbus AXI-Lite engine (m_axil_req/m_axil_resp).

---
 rtl/axil_reg_bank.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axil_reg_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_bank.sv
// ============================================================================
//  Module   : axil_reg_bank (with package axil_reg_bank_pkg)
//  Purpose  : AXI4-Lite slave register bank. It holds NumRegs registers of
//             DataWidth bits. Registers flagged in RoMask are read-only and
//             return the matching ro_i slice when read.
//  Ports    : clk, reset         clock and synchronous active-high reset
//             s_axil_req         AXI-Lite request channels (AW, W, B, AR, R)
//             s_axil_resp        AXI-Lite response channels
//             reg_o              RW register image (RO slices read as 0)
//             wr_pulse_o         one-cycle pulse per register after a commit
//             ro_i               status values returned for RO registers
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package axil_reg_bank_pkg;
  typedef struct packed { logic [31:0] addr; logic [2:0] prot; } axil_ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; } axil_w_t;
  typedef struct packed { logic [1:0] resp; } axil_b_t;
  typedef struct packed { logic [31:0] data; logic [1:0] resp; } axil_r_t;

  typedef struct packed {
    logic     aw_valid;
    axil_ax_t aw;
    logic     w_valid;
    axil_w_t  w;
    logic     b_ready;
    logic     ar_valid;
    axil_ax_t ar;
    logic     r_ready;
  } axil_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    b_valid;
    axil_b_t b;
    logic    ar_ready;
    logic    r_valid;
    axil_r_t r;
  } axil_resp_t;
endpackage

module axil_reg_bank #(
  parameter type axil_req_t                       = axil_reg_bank_pkg::axil_req_t,
  parameter type axil_resp_t                      = axil_reg_bank_pkg::axil_resp_t,
  parameter int unsigned NumRegs                  = 16,
  parameter int unsigned AddrWidth                = 32,
  parameter int unsigned DataWidth                = 32,
  parameter logic [AddrWidth-1:0] BaseAddr        = '0,
  parameter logic [NumRegs-1:0] RoMask            = '0,
  parameter logic [NumRegs*DataWidth-1:0] RstVal  = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  axil_req_t                    s_axil_req,
  output axil_resp_t                   s_axil_resp,
  output logic [NumRegs*DataWidth-1:0] reg_o,
  output logic [NumRegs-1:0]           wr_pulse_o,
  input  logic [NumRegs*DataWidth-1:0] ro_i
);

  localparam int unsigned STRB_W = DataWidth / 8;
  localparam int unsigned SHIFT  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = (NumRegs > 1) ? $clog2(NumRegs) : 1;
  localparam logic [1:0]  C_OKAY   = 2'b00;
  localparam logic [1:0]  C_SLVERR = 2'b10;

  typedef enum logic [0:0] { WR_IDLE = 1'b0, WR_RESP = 1'b1 } wr_state_e;
  typedef enum logic [0:0] { RD_IDLE = 1'b0, RD_DATA = 1'b1 } rd_state_e;

  // Register index of a byte address; low (byte-lane) bits are dropped.
  function automatic logic [AddrWidth-1:0] f_idx(input logic [AddrWidth-1:0] a);
    logic [AddrWidth-1:0] off;
    off = a - BaseAddr;
    return off >> SHIFT;
  endfunction

  function automatic logic f_hit(input logic [AddrWidth-1:0] a);
    return (a >= BaseAddr) && (f_idx(a) < AddrWidth'(NumRegs));
  endfunction

  // Handshake readies stay low for the first cycle after a reset edge.
  logic live_q;

  // ---------------------------------------------------------------- write path
  wr_state_e             wr_q, wr_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AddrWidth-1:0]  aw_addr_q, aw_addr_d;
  logic [DataWidth-1:0]  w_data_q, w_data_d;
  logic [STRB_W-1:0]     w_strb_q, w_strb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [NumRegs-1:0]    pulse_q, pulse_d;

  logic                  w_aw_ready, w_w_ready, w_b_valid;
  logic                  w_wr_en;
  logic [AddrWidth-1:0]  w_wr_addr;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [DataWidth-1:0]  w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;

  always_comb begin
    wr_d       = wr_q;
    aw_held_d  = aw_held_q;
    aw_addr_d  = aw_addr_q;
    w_held_d   = w_held_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    bresp_d    = bresp_q;
    pulse_d    = '0;
    w_aw_ready = 1'b0;
    w_w_ready  = 1'b0;
    w_b_valid  = 1'b0;
    w_wr_en    = 1'b0;
    w_wr_addr  = aw_addr_q;
    w_wr_data  = w_data_q;
    w_wr_strb  = w_strb_q;
    w_wr_idx   = '0;
    unique case (wr_q)
      WR_IDLE: begin
        w_aw_ready = live_q && !aw_held_q;
        w_w_ready  = live_q && !w_held_q;
        // Arriving beats bypass the holding registers so a same-cycle
        // AW+W (or the second half of a split pair) commits immediately.
        if (w_aw_ready && s_axil_req.aw_valid) begin
          aw_held_d = 1'b1;
          aw_addr_d = s_axil_req.aw.addr;
          w_wr_addr = s_axil_req.aw.addr;
        end
        if (w_w_ready && s_axil_req.w_valid) begin
          w_held_d  = 1'b1;
          w_data_d  = s_axil_req.w.data;
          w_strb_d  = s_axil_req.w.strb;
          w_wr_data = s_axil_req.w.data;
          w_wr_strb = s_axil_req.w.strb;
        end
        w_wr_idx = IDX_W'(f_idx(w_wr_addr));
        if (aw_held_d && w_held_d) begin
          wr_d = WR_RESP;
          if (f_hit(w_wr_addr) && !RoMask[w_wr_idx]) begin
            w_wr_en           = 1'b1;
            pulse_d[w_wr_idx] = 1'b1;
            bresp_d           = C_OKAY;
          end else begin
            bresp_d = C_SLVERR;
          end
        end
      end
      WR_RESP: begin
        w_b_valid = 1'b1;
        if (s_axil_req.b_ready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wr_d      = WR_IDLE;
        end
      end
      default: wr_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      live_q    <= 1'b0;
      wr_q      <= WR_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= C_OKAY;
      pulse_q   <= '0;
    end else begin
      live_q    <= 1'b1;
      wr_q      <= wr_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bresp_q   <= bresp_d;
      pulse_q   <= pulse_d;
    end
  end

  assign wr_pulse_o = pulse_q;

  // ------------------------------------------------------------ register file
  for (genvar i = 0; i < NumRegs; i++) begin : g_reg
    if (RoMask[i]) begin : g_ro
      assign reg_o[i*DataWidth +: DataWidth] = '0;
    end else begin : g_rw
      logic [DataWidth-1:0] val_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          val_q <= RstVal[i*DataWidth +: DataWidth];
        end else if (w_wr_en && (w_wr_idx == IDX_W'(i))) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wr_strb[b]) val_q[8*b +: 8] <= w_wr_data[8*b +: 8];
          end
        end
      end
      assign reg_o[i*DataWidth +: DataWidth] = val_q;
    end
  end

  // ----------------------------------------------------------------- read path
  rd_state_e             rd_q, rd_d;
  logic [DataWidth-1:0]  rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  w_ar_ready, w_r_valid;
  logic [IDX_W-1:0]      w_rd_idx;

  // reg_o is sampled before the clock edge, so a read that coincides with a
  // write commit returns the pre-write contents.
  always_comb begin
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    w_ar_ready = 1'b0;
    w_r_valid  = 1'b0;
    w_rd_idx   = IDX_W'(f_idx(s_axil_req.ar.addr));
    unique case (rd_q)
      RD_IDLE: begin
        w_ar_ready = live_q;
        if (w_ar_ready && s_axil_req.ar_valid) begin
          rd_d = RD_DATA;
          if (f_hit(s_axil_req.ar.addr)) begin
            rdata_d = RoMask[w_rd_idx] ? ro_i[w_rd_idx*DataWidth +: DataWidth]
                                       : reg_o[w_rd_idx*DataWidth +: DataWidth];
            rresp_d = C_OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = C_SLVERR;
          end
        end
      end
      RD_DATA: begin
        w_r_valid = 1'b1;
        if (s_axil_req.r_ready) rd_d = RD_IDLE;
      end
      default: rd_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= RD_IDLE;
      rdata_q <= '0;
      rresp_q <= C_OKAY;
    end else begin
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  // ------------------------------------------------------------ response pack
  always_comb begin
    s_axil_resp          = '0;
    s_axil_resp.aw_ready = w_aw_ready;
    s_axil_resp.w_ready  = w_w_ready;
    s_axil_resp.b_valid  = w_b_valid;
    s_axil_resp.b.resp   = bresp_q;
    s_axil_resp.ar_ready = w_ar_ready;
    s_axil_resp.r_valid  = w_r_valid;
    s_axil_resp.r.data   = rdata_q;
    s_axil_resp.r.resp   = rresp_q;
  end

  // Protection bits carry no meaning for this bank.
  logic w_unused;
  assign w_unused = ^{s_axil_req.aw.prot, s_axil_req.ar.prot};

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_bank.sv
// ============================================================================
//  Module   : tb_axil_reg_bank
//  Purpose  : Directed, self-checking bench for axil_reg_bank. Expected B and
//             R responses are queued by the stimulus and popped by monitors
//             on each handshake; cycle-exact state is checked inline.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axil_reg_bank;
  import axil_reg_bank_pkg::*;

  localparam logic [31:0]  BASE   = 32'h0000_1000;
  localparam logic [15:0]  ROMASK = 16'h0020;
  localparam logic [511:0] RSTVAL = 512'hA5A5_0000 << (3 * 32);

  logic         clk = 1'b0;
  logic         reset;
  axil_req_t    req;
  axil_resp_t   resp;
  logic [511:0] reg_o;
  logic [15:0]  wr_pulse_o;
  logic [511:0] ro_i;

  int n_vec = 0;
  int n_err = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  always #5 clk = ~clk;

  axil_reg_bank #(
    .NumRegs  (16),
    .AddrWidth(32),
    .DataWidth(32),
    .BaseAddr (BASE),
    .RoMask   (ROMASK),
    .RstVal   (RSTVAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .s_axil_req (req),
    .s_axil_resp(resp),
    .reg_o      (reg_o),
    .wr_pulse_o (wr_pulse_o),
    .ro_i       (ro_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rg(input int i);
    return reg_o[i*32 +: 32];
  endfunction

  // Monitors: compare every completed B / R handshake against the queue.
  always @(negedge clk) begin
    if (!reset && resp.b_valid && req.b_ready) begin
      if (exp_b.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL b_unexpected: got resp %b, expected none", resp.b.resp);
      end else begin
        chk("b_resp", 64'(resp.b.resp), 64'(exp_b.pop_front()));
      end
    end
    if (!reset && resp.r_valid && req.r_ready) begin
      if (exp_r.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL r_unexpected: got %h, expected none", {resp.r.data, resp.r.resp});
      end else begin
        chk("r_beat", 64'({resp.r.data, resp.r.resp}), 64'(exp_r.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    req.aw_valid = 1'b1; req.aw.addr = addr;
    req.w_valid  = 1'b1; req.w.data  = data; req.w.strb = strb;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    drive_w(addr, data, strb);
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr);
    req.ar_valid = 1'b1; req.ar.addr = addr;
    tick();
    req.ar_valid = 1'b0;
  endtask

  task automatic finish_b(input logic [1:0] exp);
    exp_b.push_back(exp);
    req.b_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (resp.b_valid) begin
        tick();
        req.b_ready = 1'b0;
        return;
      end
      tick();
    end
    req.b_ready = 1'b0;
    n_vec++; n_err++;
    $display("FAIL b_timeout: got no b_valid, expected one within 20 cycles");
  endtask

  task automatic finish_r(input logic [31:0] data, input logic [1:0] rsp);
    exp_r.push_back({data, rsp});
    req.r_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (resp.r_valid) begin
        tick();
        req.r_ready = 1'b0;
        return;
      end
      tick();
    end
    req.r_ready = 1'b0;
    n_vec++; n_err++;
    $display("FAIL r_timeout: got no r_valid, expected one within 20 cycles");
  endtask

  function automatic logic [4:0] hs();
    return {resp.aw_ready, resp.w_ready, resp.ar_ready, resp.b_valid, resp.r_valid};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] snap;
    reset = 1'b1;
    req   = '0;
    ro_i  = '0;
    ro_i[5*32 +: 32] = 32'hCAFE_0005;
    ro_i[2*32 +: 32] = 32'h5555_5555;

    // Reset state
    tick(); tick();
    chk("rst_handshake", 64'(hs()), 64'(5'b00000));
    chk("rst_reg3", 64'(rg(3)), 64'h0000_0000_A5A5_0000);
    chk("rst_reg2", 64'(rg(2)), 64'h0);
    chk("rst_pulse", 64'(wr_pulse_o), 64'h0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", 64'(hs()), 64'(5'b11100));

    // Same-cycle AW+W write to reg2
    do_write(BASE + 32'h8, 32'h1234_5678, 4'hF);
    chk("wr_reg2", 64'(rg(2)), 64'h1234_5678);
    chk("wr_bvalid", 64'(resp.b_valid), 64'h1);
    chk("wr_pulse", 64'(wr_pulse_o), 64'h0004);
    finish_b(2'b00);
    chk("wr_pulse_gone", 64'(wr_pulse_o), 64'h0);

    // W three cycles ahead of AW, partial strobe
    req.w_valid = 1'b1; req.w.data = 32'hFFFF_FFFF; req.w.strb = 4'b0011;
    tick();
    req.w_valid = 1'b0;
    chk("split_ready", 64'({resp.aw_ready, resp.w_ready}), 64'(2'b10));
    tick(); tick();
    chk("split_no_b", 64'(resp.b_valid), 64'h0);
    chk("split_reg2_hold", 64'(rg(2)), 64'h1234_5678);
    req.aw_valid = 1'b1; req.aw.addr = BASE + 32'h8;
    tick();
    req.aw_valid = 1'b0;
    chk("split_reg2", 64'(rg(2)), 64'h1234_FFFF);
    chk("split_bvalid", 64'(resp.b_valid), 64'h1);
    finish_b(2'b00);

    // Read back with 5 cycles of r_ready backpressure
    do_read(BASE + 32'h8);
    chk("rd_rvalid", 64'(resp.r_valid), 64'h1);
    chk("rd_data", 64'(resp.r.data), 64'h1234_FFFF);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rd_stall", 64'({resp.r_valid, resp.ar_ready, resp.r.data}), {30'h0, 2'b10, 32'h1234_FFFF});
    end
    finish_r(32'h1234_FFFF, 2'b00);

    // Zero strobe on an RW hit: OKAY, pulse, no change
    do_write(BASE + 32'h4, 32'hFFFF_FFFF, 4'h0);
    chk("strb0_pulse", 64'(wr_pulse_o), 64'h0002);
    chk("strb0_reg1", 64'(rg(1)), 64'h0);
    finish_b(2'b00);

    // Out-of-range write
    snap = reg_o;
    do_write(BASE + 32'h40, 32'hDEAD_BEEF, 4'hF);
    chk("miss_pulse", 64'(wr_pulse_o), 64'h0);
    chk("miss_noupdate", 64'(reg_o == snap), 64'h1);
    finish_b(2'b10);

    // Write to read-only reg5
    do_write(BASE + 32'h14, 32'hDEAD_BEEF, 4'hF);
    chk("ro_pulse", 64'(wr_pulse_o), 64'h0);
    chk("ro_noupdate", 64'(reg_o == snap), 64'h1);
    finish_b(2'b10);

    // Reads: RO reg5, miss, reset-valued reg3
    do_read(BASE + 32'h14);
    finish_r(32'hCAFE_0005, 2'b00);
    do_read(BASE + 32'h40);
    finish_r(32'h0, 2'b10);
    do_read(BASE + 32'hC);
    finish_r(32'hA5A5_0000, 2'b00);

    // Read and write commit to reg2 in the same cycle
    drive_w(BASE + 32'h8, 32'h0BAD_0002, 4'hF);
    req.ar_valid = 1'b1; req.ar.addr = BASE + 32'h8;
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0; req.ar_valid = 1'b0;
    chk("coll_reg2", 64'(rg(2)), 64'h0BAD_0002);
    chk("coll_rdata", 64'(resp.r.data), 64'h1234_FFFF);
    finish_b(2'b00);
    finish_r(32'h1234_FFFF, 2'b00);

    // Reset while b_valid is pending
    do_write(BASE + 32'h0, 32'h1111_1111, 4'hF);
    chk("prerst_bvalid", 64'(resp.b_valid), 64'h1);
    chk("prerst_reg0", 64'(rg(0)), 64'h1111_1111);
    reset = 1'b1;
    tick();
    chk("midrst_handshake", 64'(hs()), 64'(5'b00000));
    chk("midrst_image", 64'(reg_o == RSTVAL), 64'h1);
    reset = 1'b0;
    tick();
    chk("postrst_ready", 64'(hs()), 64'(5'b11100));
    do_read(BASE + 32'h8);
    finish_r(32'h0, 2'b00);

    tick();
    chk("b_queue_empty", 64'(exp_b.size()), 64'h0);
    chk("r_queue_empty", 64'(exp_r.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
